// File: rtl/dmem_responder.sv
// dmem_responder: MEM-stage data-memory responder.
//
// Services byte, halfword and word loads and stores against an internal big-endian byte
// array. Each access takes a fixed LATENCY wait cycles. The upstream pipeline registers are
// held meanwhile through a combinational stall. Load data is sign- or zero-extended and then
// registered for the MEM/WB stage.
//
// Parameters:
//   DEPTH   - memory size in bytes (power of two, >= 4)
//   LATENCY - wait cycles per access (>= 1)
//
// Ports:
//   clk             - clock, rising edge
//   reset           - asynchronous, active-high reset
//   mem_enable_i    - request valid (EX/MEM register)
//   mem_rw_i        - 1 = store, 0 = load
//   mem_size_i      - 00 byte, 01 halfword, 10/11 word
//   mem_se_i        - 1 = sign-extend load result
//   addr_i          - byte address; wraps modulo DEPTH
//   wdata_i         - store data, right-justified for byte/halfword
//   stall_o         - hold PC, IF/ID, ID/EX, EX/MEM
//   rdata_o         - registered, extended load result
//   rdata_valid_o   - one-cycle pulse when rdata_o is updated by a load
//   misaligned_o    - one-cycle pulse on a rejected misaligned request
//
// Build option DMEM_MISALIGN_TRAP_EN:
//   defined   - misaligned requests are rejected, and misaligned_o pulses for each one
//   undefined - misaligned addresses are force-aligned and serviced; misaligned_o stays 0
module dmem_responder #(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable_i,
  input  logic        mem_rw_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_se_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        misaligned_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    size_q;
  logic          se_q;
  logic          rw_q;
  logic [31:0]   rdata_q;
  logic          rdata_valid_q;
  logic          misaligned_q;

  logic [7:0]    mem_q [DEPTH];

  // Address bits above the memory size are ignored, so addresses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_i[31:AW];

  logic          req_half;
  logic          req_word;
  logic          aligned;
  logic [AW-1:0] req_addr;

  assign req_half = (mem_size_i == 2'b01);
  assign req_word = mem_size_i[1];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic req_mis;
  assign req_mis  = (req_half & addr_i[0]) | (req_word & (addr_i[1:0] != 2'b00));
  assign aligned  = ~req_mis;
  assign req_addr = addr_i[AW-1:0];
`else
  // Clear the low address bits so that any request is serviced as an aligned one.
  logic [1:0] low_mask;
  assign low_mask = req_word ? 2'b11 : (req_half ? 2'b01 : 2'b00);
  assign aligned  = 1'b1;
  assign req_addr = addr_i[AW-1:0] & {{(AW - 2){1'b1}}, ~low_mask};
`endif

  // The access happens on the edge that leaves WAIT.
  logic access_fire;
  assign access_fire = (state_q == StWait) && (cnt_q == CW'(1));

  // Byte addresses of the access. Aligned accesses never cross the end of the memory. Wrapping
  // the additions keeps unused lanes in range.
  logic [AW-1:0] addr_p1;
  logic [AW-1:0] addr_p2;
  logic [AW-1:0] addr_p3;
  assign addr_p1 = addr_q + AW'(1);
  assign addr_p2 = addr_q + AW'(2);
  assign addr_p3 = addr_q + AW'(3);

  // Big-endian: the lowest address holds the most significant byte.
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  assign ld_word = {mem_q[addr_q], mem_q[addr_p1], mem_q[addr_p2], mem_q[addr_p3]};

  always_comb begin
    ld_ext = ld_word;
    unique case (size_q)
      2'b00:   ld_ext = {{24{se_q & ld_word[31]}}, ld_word[31:24]};
      2'b01:   ld_ext = {{16{se_q & ld_word[31]}}, ld_word[31:16]};
      default: ld_ext = ld_word;
    endcase
  end

  // Memory contents are not reset. A reset during WAIT forces the state to IDLE, and that stops
  // the pending store.
  always_ff @(posedge clk) begin
    if (access_fire && rw_q) begin
      unique case (size_q)
        2'b00: mem_q[addr_q] <= wdata_q[7:0];
        2'b01: begin
          mem_q[addr_q]  <= wdata_q[15:8];
          mem_q[addr_p1] <= wdata_q[7:0];
        end
        default: begin
          mem_q[addr_q]  <= wdata_q[31:24];
          mem_q[addr_p1] <= wdata_q[23:16];
          mem_q[addr_p2] <= wdata_q[15:8];
          mem_q[addr_p3] <= wdata_q[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      size_q        <= '0;
      se_q          <= 1'b0;
      rw_q          <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      rdata_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (mem_enable_i && aligned) begin
            addr_q  <= req_addr;
            wdata_q <= wdata_i;
            size_q  <= mem_size_i;
            se_q    <= mem_se_i;
            rw_q    <= mem_rw_i;
            cnt_q   <= CW'(LATENCY);
            state_q <= StWait;
          end
`ifdef DMEM_MISALIGN_TRAP_EN
          else if (mem_enable_i) begin
            misaligned_q <= 1'b1;
          end
`endif
        end
        StWait: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= StDone;
            if (!rw_q) begin
              rdata_q       <= ld_ext;
              rdata_valid_q <= 1'b1;
            end
          end
        end
        // EX/MEM still shows the request just serviced, so mem_enable_i is ignored here.
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_o       = ((state_q == StIdle) & mem_enable_i & aligned) | (state_q == StWait);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. A byte-array reference model computes load results
// with plain arithmetic. Directed steps come first, then random accesses.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic        mem_rw;
  logic [1:0]  mem_size;
  logic        mem_se;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        misaligned_o;

  dmem_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .mem_enable_i  (mem_enable),
    .mem_rw_i      (mem_rw),
    .mem_size_i    (mem_size),
    .mem_se_i      (mem_se),
    .addr_i        (addr),
    .wdata_i       (wdata),
    .stall_o       (stall_o),
    .rdata_o       (rdata_o),
    .rdata_valid_o (rdata_valid_o),
    .misaligned_o  (misaligned_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned ref_mem [DEPTH];
  logic [31:0]  ref_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : ((size == 2'b01) ? 2 : 4);
  endfunction

  function automatic bit is_mis(input logic [1:0] size, input logic [31:0] a);
    return (a % nbytes(size)) != 0;
  endfunction

  // Effective byte address: wrap modulo DEPTH, then round down to the access size.
  function automatic int unsigned eff_addr(input logic [1:0] size, input logic [31:0] a);
    int unsigned e;
    e = a % DEPTH;
    return e - (e % nbytes(size));
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] size, input logic se,
                                           input logic [31:0] a);
    longint unsigned v;
    int unsigned     e;
    int unsigned     n;
    e = eff_addr(size, a);
    n = nbytes(size);
    v = 0;
    for (int i = 0; i < int'(n); i++) v = v * 256 + ref_mem[(e + i) % DEPTH];
    if (se && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [1:0] size, input logic [31:0] a, input logic [31:0] d);
    int unsigned e;
    int unsigned n;
    e = eff_addr(size, a);
    n = nbytes(size);
    for (int i = 0; i < int'(n); i++) ref_mem[(e + i) % DEPTH] = 8'((d >> (8 * (n - 1 - i))) % 256);
  endtask

  // One complete request. Its expectations come from the model, and the model is updated.
  task automatic access(input logic rw, input logic [1:0] size, input logic se,
                        input logic [31:0] a, input logic [31:0] d);
    bit          trap;
    int          n;
    logic [31:0] exp_v;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = is_mis(size, a);
`else
    trap = 1'b0;
`endif
    @(posedge clk);
    #1;
    mem_enable = 1'b1;
    mem_rw     = rw;
    mem_size   = size;
    mem_se     = se;
    addr       = a;
    wdata      = d;
    if (trap) begin
      @(negedge clk);
      chk("mis_stall", 32'(stall_o), 32'd0);
      chk("mis_pre", 32'(misaligned_o), 32'd0);
      @(posedge clk);
      #1 mem_enable = 1'b0;
      @(negedge clk);
      chk("mis_pulse", 32'(misaligned_o), 32'd1);
      chk("mis_rvalid", 32'(rdata_valid_o), 32'd0);
      chk("mis_rdata", rdata_o, ref_rdata);
      @(negedge clk);
      chk("mis_end", 32'(misaligned_o), 32'd0);
    end else begin
      exp_v = ref_load(size, se, a);
      n = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!stall_o) break;
        n++;
      end
      chk("stall_len", 32'(n), 32'(LATENCY + 1));
      if (rw) ref_store(size, a, d);
      else    ref_rdata = exp_v;
      chk("done_rvalid", 32'(rdata_valid_o), 32'(!rw));
      chk("done_rdata", rdata_o, ref_rdata);
      chk("done_mis", 32'(misaligned_o), 32'd0);
      @(posedge clk);
      #1 mem_enable = 1'b0;
      @(negedge clk);
      chk("post_rvalid", 32'(rdata_valid_o), 32'd0);
      chk("post_stall", 32'(stall_o), 32'd0);
      chk("post_rdata", rdata_o, ref_rdata);
    end
  endtask

  initial begin
    reset      = 1'b1;
    mem_enable = 1'b0;
    mem_rw     = 1'b0;
    mem_size   = 2'b00;
    mem_se     = 1'b0;
    addr       = '0;
    wdata      = '0;
    ref_rdata  = '0;

    @(negedge clk);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_rvalid", 32'(rdata_valid_o), 32'd0);
    chk("rst_mis", 32'(misaligned_o), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Fill the memory so that the model knows every byte.
    for (int a = 0; a < int'(DEPTH); a += 4) access(1'b1, 2'b10, 1'b0, 32'(a), $urandom);

    // Directed steps from the feature list.
    access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    access(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
    chk("lb_const", rdata_o, 32'hFFFFFFAD);
    access(1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    chk("lbu_const", rdata_o, 32'h000000AD);
    access(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    chk("lh_const", rdata_o, 32'hFFFFBEEF);
    access(1'b1, 2'b00, 1'b0, 32'h13, 32'h12345655);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_byte_merge", rdata_o, 32'hDEADBE55);
    access(1'b1, 2'b10, 1'b0, 32'h210, 32'hCAFEF00D);
    access(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk("lw_wrap", rdata_o, 32'hCAFEF00D);

    // A reset during WAIT stops the store.
    access(1'b1, 2'b10, 1'b0, 32'h20, 32'h0);
    @(posedge clk);
    #1;
    mem_enable = 1'b1;
    mem_rw     = 1'b1;
    mem_size   = 2'b10;
    addr       = 32'h20;
    wdata      = 32'h11111111;
    @(negedge clk);
    chk("rstmid_stall_pre", 32'(stall_o), 32'd1);
    @(posedge clk);
    #1;
    mem_enable = 1'b0;
    reset      = 1'b1;
    #1;
    chk("rstmid_stall", 32'(stall_o), 32'd0);
    ref_rdata = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstmid_rdata", rdata_o, 32'd0);
    chk("rstmid_rvalid", 32'(rdata_valid_o), 32'd0);
    access(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    chk("rstmid_lw", rdata_o, 32'h00000000);

    // Misaligned word load: trapped, or serviced as the word at 0x10.
    access(1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
`ifndef DMEM_MISALIGN_TRAP_EN
    chk("lw_forced", rdata_o, 32'hCAFEF00D);
`endif

    // Random traffic.
    for (int k = 0; k < 80; k++) begin
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
